// File: rtl/mux8_pkg.sv
// mux8_pkg: shared constants and helpers for the 8-way round-robin merge path.
//   N_CH    - number of input channels
//   SEL_W   - width of a channel index
//   PTR_RST - round-robin pointer value after reset (channel 0 scanned first)
//   oh2idx  - one-hot to binary index encoder
package mux8_pkg;

  localparam int N_CH  = 8;
  localparam int SEL_W = 3;
  localparam logic [SEL_W-1:0] PTR_RST = 3'd7;

  // One-hot to index; a zero vector encodes to index 0.
  function automatic logic [SEL_W-1:0] oh2idx(input logic [N_CH-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = 3'd0;
    for (int i = 0; i < N_CH; i++) begin
      idx = idx | (oh[i] ? i[SEL_W-1:0] : 3'd0);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_8way_rr_arb8.sv
// rr_arb8: purely combinational 8-way arbiter.
//   Default build: round-robin, scanning (last+1) .. (last+8) mod 8.
//   With MUX8_FIXED_PRIO_EN defined: fixed priority, lowest channel wins,
//   and the last input is ignored.
// Ports:
//   req  [7:0] in  - per-channel requests
//   last [2:0] in  - most recently granted channel
//   en         in  - when low, no grant is issued
//   gnt  [7:0] out - one-hot grant, or zero
module rr_arb8
  import mux8_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] last,
  input  logic             en,
  output logic [N_CH-1:0]  gnt
);

  logic             w_found;
  logic [SEL_W-1:0] w_ch;

`ifdef MUX8_FIXED_PRIO_EN
  logic w_unused_last;
  assign w_unused_last = ^last;

  // Fixed priority: the first requester from channel 0 upward wins.
  always_comb begin
    gnt     = 8'd0;
    w_found = 1'b0;
    w_ch    = 3'd0;
    for (int i = 0; i < N_CH; i++) begin
      w_ch      = i[SEL_W-1:0];
      gnt[w_ch] = en & ~w_found & req[w_ch];
      w_found   = w_found | req[w_ch];
    end
  end
`else
  // Round-robin: the 3-bit add wraps naturally, and k=8 lands on last itself,
  // so the previous winner is considered only after everyone else.
  always_comb begin
    gnt     = 8'd0;
    w_found = 1'b0;
    w_ch    = 3'd0;
    for (int k = 1; k <= N_CH; k++) begin
      w_ch      = last + k[SEL_W-1:0];
      gnt[w_ch] = en & ~w_found & req[w_ch];
      w_found   = w_found | req[w_ch];
    end
  end
`endif

endmodule

// File: rtl/mux_8way_rr.sv
// mux_8way_rr: merges eight valid/ready channels into one registered output
// stream. Each output word is tagged with its 3-bit source channel index.
// Arbitration is round-robin unless MUX8_FIXED_PRIO_EN is defined, in which
// case the lowest-numbered valid channel always wins and no pointer exists.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   in_valid[7:0]         - per-channel valid
//   in_data[8*WIDTH-1:0]  - channel i at [i*WIDTH +: WIDTH]
//   in_ready[7:0]         - per-channel ready, one-hot or zero
//   out_valid/out_data/out_sel - registered output word and its source index
//   out_ready             - downstream accepts the word
//   out_count[CNT_W-1:0]  - words accepted downstream, wrapping
module mux_8way_rr
  import mux8_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      out_count
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_sel;
  logic [CNT_W-1:0] r_count;

  logic [SEL_W-1:0] w_last;
  logic             w_load_ok;
  logic             w_en;
  logic [N_CH-1:0]  w_gnt;
  logic             w_xfer;
  logic [SEL_W-1:0] w_idx;
  logic             w_drain;

  // The register may load when it is empty or being drained this cycle;
  // reset suppresses every ready so nothing is accepted during reset.
  assign w_load_ok = ~r_out_valid | out_ready;
  assign w_en      = w_load_ok & ~reset;
  assign w_drain   = r_out_valid & out_ready;

  rr_arb8 u_arb (
    .req  (in_valid),
    .last (w_last),
    .en   (w_en),
    .gnt  (w_gnt)
  );

  // A grant already implies valid and load_ok, so it is the transfer itself.
  assign in_ready = w_gnt;
  assign w_xfer   = |w_gnt;
  assign w_idx    = oh2idx(w_gnt);

`ifdef MUX8_FIXED_PRIO_EN
  assign w_last = PTR_RST;
`else
  logic [SEL_W-1:0] r_last;
  assign w_last = r_last;

  // Round-robin pointer: moves only when a transfer happens.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= PTR_RST;
    end else if (w_xfer) begin
      r_last <= w_idx;
    end
  end
`endif

  // Output register: load on transfer, empty on drain without reload.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= 3'd0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= in_data[w_idx*WIDTH +: WIDTH];
      r_out_sel   <= w_idx;
    end else if (w_drain) begin
      r_out_valid <= 1'b0;
    end
  end

  // Accepted-word counter, wraps modulo 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_drain) begin
      r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_count = r_count;

endmodule

// File: tb/tb_mux_8way_rr.sv
// tb_mux_8way_rr: directed scenarios plus randomized traffic for mux_8way_rr,
// checked cycle by cycle against a behavioural model of the merge rules.
module tb_mux_8way_rr;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [7:0]           in_valid;
  logic [8*WIDTH-1:0]   in_data;
  logic [7:0]           in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [2:0]           out_sel;
  logic                 out_ready;
  logic [CNT_W-1:0]     out_count;

  always #5 clk = ~clk;

  mux_8way_rr #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready),
    .out_count (out_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Source side: a pending word stays offered until the model grants it.
  logic [7:0]       pend;
  logic [WIDTH-1:0] pdat [8];

  // Reference model state.
  bit               m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_sel;
  int               m_count;
  int               m_last;
  int               m_g;
  logic [7:0]       s_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_pick(input logic [7:0] req, input int last);
`ifdef MUX8_FIXED_PRIO_EN
    for (int i = 0; i < 8; i++) if (req[i]) return i;
`else
    for (int k = 1; k <= 8; k++) if (req[(last + k) % 8]) return (last + k) % 8;
`endif
    return -1;
  endfunction

  // One clock: drive, check ready before the edge, update model, check outputs.
  task automatic cycle();
    in_valid = pend;
    for (int i = 0; i < 8; i++) in_data[i*WIDTH +: WIDTH] = pdat[i];
    @(negedge clk);
    m_g = (!reset && (!m_valid || out_ready)) ? ref_pick(pend, m_last) : -1;
    s_ready = in_ready;
    check("in_ready", {24'd0, in_ready}, (m_g < 0) ? 32'd0 : (32'd1 << m_g));
    @(posedge clk);
    if (reset) begin
      m_valid = 0; m_data = '0; m_sel = 0; m_count = 0; m_last = 7;
    end else begin
      if (m_valid && out_ready) m_count = (m_count + 1) % (1 << CNT_W);
      if (m_g >= 0) begin
        m_valid = 1; m_data = pdat[m_g]; m_sel = m_g; m_last = m_g;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
    end
    if (m_g >= 0) pend[m_g] = 1'b0;
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("out_data",  {24'd0, out_data},  {24'd0, m_data});
    check("out_sel",   {29'd0, out_sel},   m_sel);
    check("out_count", {28'd0, out_count}, m_count);
  endtask

  task automatic do_reset();
    reset = 1'b1; pend = 8'd0; out_ready = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic all_valid();
    pend = 8'hFF;
    for (int i = 0; i < 8; i++) pdat[i] = 8'h10 + i[7:0];
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b0; pend = 8'd0;
    in_valid = 8'd0; in_data = '0;
    for (int i = 0; i < 8; i++) pdat[i] = 8'd0;
    m_valid = 0; m_data = '0; m_sel = 0; m_count = 0; m_last = 7; m_g = -1;

    // Reset state.
    do_reset();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_count", {28'd0, out_count}, 32'd0);

    // Single channel 3 transfer.
    out_ready = 1'b1; pend = 8'h08; pdat[3] = 8'hA5;
    cycle();
    check("t1_ready", {24'd0, s_ready}, 32'h08);
    check("t1_data",  {24'd0, out_data}, 32'hA5);
    check("t1_sel",   {29'd0, out_sel}, 32'd3);

    // Fairness with all channels valid.
    do_reset();
    out_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      all_valid();
      cycle();
`ifdef MUX8_FIXED_PRIO_EN
      check("rr_seq", {29'd0, out_sel}, 32'd0);
`else
      check("rr_seq", {29'd0, out_sel}, n % 8);
`endif
    end
    pend = 8'd0;
    cycle();
    check("rr_count", {28'd0, out_count}, 32'd0); // 16 mod 2^4

    // Output stall with channels 2 and 6.
    do_reset();
    pend = 8'h44; pdat[2] = 8'h22; pdat[6] = 8'h66; out_ready = 1'b0;
    cycle();
    check("st_first", {29'd0, out_sel}, 32'd2);
    for (int n = 0; n < 5; n++) begin
      cycle();
      check("st_hold_sel", {29'd0, out_sel}, 32'd2);
      check("st_hold_rdy", {24'd0, s_ready}, 32'd0);
    end
    out_ready = 1'b1;
    cycle();
    check("st_next", {29'd0, out_sel}, 32'd6);
    check("st_data", {24'd0, out_data}, 32'h66);
    cycle();
    check("st_empty", {31'd0, out_valid}, 32'd0);

    // Wrap-around: last grant on 6, then channels 1 and 7.
    do_reset();
    out_ready = 1'b1; pend = 8'h40; pdat[6] = 8'h06;
    cycle();
    pend = 8'h82; pdat[1] = 8'h01; pdat[7] = 8'h07;
    cycle();
`ifdef MUX8_FIXED_PRIO_EN
    check("wrap_a", {29'd0, out_sel}, 32'd1);
    cycle();
    check("wrap_b", {29'd0, out_sel}, 32'd7);
`else
    check("wrap_a", {29'd0, out_sel}, 32'd7);
    cycle();
    check("wrap_b", {29'd0, out_sel}, 32'd1);
`endif

    // Counter wrap: 17 accepted words with a 4-bit counter.
    do_reset();
    out_ready = 1'b1;
    for (int n = 0; n < 17; n++) begin
      all_valid();
      cycle();
    end
    pend = 8'd0;
    cycle();
    check("cnt_wrap", {28'd0, out_count}, 32'd1);

    // Reset while a word is held and stalled.
    do_reset();
    out_ready = 1'b0; pend = 8'h10; pdat[4] = 8'h44;
    cycle();
    check("mr_loaded", {31'd0, out_valid}, 32'd1);
    reset = 1'b1; pend = 8'h11; pdat[0] = 8'hC0;
    cycle();
    check("mr_valid", {31'd0, out_valid}, 32'd0);
    check("mr_count", {28'd0, out_count}, 32'd0);
    check("mr_rdy",   {24'd0, s_ready}, 32'd0);
    reset = 1'b0; out_ready = 1'b1;
    cycle();
    check("mr_grant0", {29'd0, out_sel}, 32'd0);

    // Randomized traffic with occasional stalls and resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 199) == 0);
      if (reset) pend = 8'd0;
      for (int i = 0; i < 8; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pdat[i] = 8'($urandom);
        end
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
